country_sensor_conditioner: RTL and testbench

- Sits directly upstream of the highway/country traffic-light controller and produces its country-road car request `X`.
- Synchronises and debounces the raw inductive-loop sensor and counts car arrivals.
- Holds the request until the controller has served the country road, so short pulses are never lost and a stuck loop cannot lock the highway red.
- Reads back the controller's country-light output `C` to know when service has happened.

---
 rtl/traffic_pkg.sv | 20 ++
 rtl/country_sensor_conditioner_if.sv | 36 +++
 rtl/sync_debounce.sv | 48 ++++
 rtl/country_sensor_conditioner.sv | 115 +++++++++++
 tb/tb_country_sensor_conditioner.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the highway/country traffic-light controller and the
// country-road sensor conditioner that feeds it.
//   - light_t        : two-bit light encoding driven by the controller
//   - RED/YELLOW/GREEN : light encodings (3 is unused and reads as red)
//   - sensor_state_e : request FSM states of the sensor conditioner
package traffic_pkg;

  typedef logic [1:0] light_t;

  localparam light_t RED    = 2'd0;
  localparam light_t YELLOW = 2'd1;
  localparam light_t GREEN  = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    SERVING
  } sensor_state_e;

endpackage

// File: rtl/country_sensor_conditioner_if.sv
// Signal bundle between the loop sensor / controller side and the sensor
// conditioner.
//   sensor_raw : raw inductive-loop detector, asynchronous, may bounce
//   C          : country light currently driven by the controller
//   X          : registered country-road car request
//   pending    : registered count of arrived, unserved cars
//   stuck      : registered sticky stuck-sensor flag
// Modports: master drives sensor_raw/C, slave (the conditioner) drives X/pending/stuck.
interface country_sensor_conditioner_if #(
  parameter int unsigned CNT_W = 3
);
  import traffic_pkg::*;

  logic             sensor_raw;
  light_t           C;
  logic             X;
  logic [CNT_W-1:0] pending;
  logic             stuck;

  modport master (
    output sensor_raw,
    output C,
    input  X,
    input  pending,
    input  stuck
  );

  modport slave (
    input  sensor_raw,
    input  C,
    output X,
    output pending,
    output stuck
  );

endinterface

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a debounce filter. The debounced level only
// follows the synchronised input after DEBOUNCE_CYCLES consecutive differing
// samples.
//   clock : system clock, rising edge
//   clear : asynchronous active-high reset
//   din   : asynchronous raw input
//   dout  : debounced level
module sync_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic clear,
  input  logic din,
  output logic dout
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            s1_q, s2_q, deb_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
      if (s2_q != deb_q) begin
        if (cnt_q == CntLast) begin
          deb_q <= s2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end else begin
        // Any sample agreeing with the current level restarts the run.
        cnt_q <= '0;
      end
    end
  end

  assign dout = deb_q;

endmodule

// File: rtl/country_sensor_conditioner.sv
// Conditions the country-road loop sensor into the controller's car request X.
// Arrivals (debounced rising edges) are counted while a request is pending, the
// request is held until the country light has been green and left green, and a
// loop that stays occupied for STUCK_CYCLES is flagged stuck so it cannot keep
// requesting forever.
//   clock : system clock, rising edge
//   clear : asynchronous active-high reset
//   bus   : slave side of country_sensor_conditioner_if (sensor_raw, C in;
//           X, pending, stuck out, all outputs registered)
module country_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned STUCK_CYCLES    = 64,
  parameter int unsigned CNT_W           = 3
) (
  input logic                         clock,
  input logic                         clear,
  country_sensor_conditioner_if.slave bus
);

  localparam int unsigned StuckW = $clog2(STUCK_CYCLES + 1);
  localparam logic [StuckW-1:0] StuckLimit = StuckW'(STUCK_CYCLES);
  localparam logic [CNT_W-1:0] PendMax = '1;

  logic              deb, deb_q;
  logic [StuckW-1:0] stuck_cnt_q, stuck_cnt_d;
  logic              stuck_q, stuck_d;
  sensor_state_e     state_q, state_d;
  logic [CNT_W-1:0]  pending_q, pending_d;
  logic              x_q;
  logic              arrival, green;

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clock(clock),
    .clear(clear),
    .din  (bus.sensor_raw),
    .dout (deb)
  );

  always_comb begin
    stuck_cnt_d = stuck_cnt_q;
    if (!deb) begin
      stuck_cnt_d = '0;
    end else if (!stuck_q && (stuck_cnt_q != StuckLimit)) begin
      stuck_cnt_d = stuck_cnt_q + StuckW'(1);
    end
    stuck_d = stuck_q | (stuck_cnt_q == StuckLimit);
  end

  assign arrival = deb & ~deb_q & ~stuck_q;
  assign green   = (bus.C == GREEN);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    unique case (state_q)
      IDLE: begin
        // Green seen while idle is not ours to act on.
        if (arrival) begin
          state_d   = REQUEST;
          pending_d = CNT_W'(1);
        end
      end
      REQUEST: begin
        if (green) begin
          state_d = SERVING;
        end else if (arrival && (pending_q != PendMax)) begin
          pending_d = pending_q + CNT_W'(1);
        end
      end
      SERVING: begin
        if (!green) begin
          // A car still sitting on a healthy loop needs another green.
          if (deb && !stuck_q) begin
            state_d   = REQUEST;
            pending_d = CNT_W'(1);
          end else begin
            state_d   = IDLE;
            pending_d = '0;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      deb_q       <= 1'b0;
      stuck_cnt_q <= '0;
      stuck_q     <= 1'b0;
      state_q     <= IDLE;
      pending_q   <= '0;
      x_q         <= 1'b0;
    end else begin
      deb_q       <= deb;
      stuck_cnt_q <= stuck_cnt_d;
      stuck_q     <= stuck_d;
      state_q     <= state_d;
      pending_q   <= pending_d;
      x_q         <= (state_d != IDLE);
    end
  end

  assign bus.X       = x_q;
  assign bus.pending = pending_q;
  assign bus.stuck   = stuck_q;

endmodule

// File: tb/tb_country_sensor_conditioner.sv
// Directed bench for country_sensor_conditioner with DEBOUNCE_CYCLES=4,
// STUCK_CYCLES=64, CNT_W=3. Outputs are sampled 1 time unit after each rising edge.
module tb_country_sensor_conditioner;
  import traffic_pkg::*;

  logic clock;
  logic clear;
  int   checks;
  int   failures;

  country_sensor_conditioner_if #(.CNT_W(3)) bus ();

  country_sensor_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .STUCK_CYCLES   (64),
    .CNT_W          (3)
  ) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic press(input int hi, input int lo);
    bus.sensor_raw = 1'b1;
    tick(hi);
    bus.sensor_raw = 1'b0;
    tick(lo);
  endtask

  // From IDLE with a settled low loop: X must rise exactly at edge 7.
  task automatic latency_check(input string tag);
    bus.sensor_raw = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick(1);
      check($sformatf("%s_x_edge%0d", tag, e), 32'(bus.X), 32'(e >= 7));
    end
    check({tag, "_pending"}, 32'(bus.pending), 1);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    clear          = 1'b1;
    bus.sensor_raw = 1'b0;
    bus.C          = RED;
    #12;
    check("reset_x", 32'(bus.X), 0);
    check("reset_pending", 32'(bus.pending), 0);
    check("reset_stuck", 32'(bus.stuck), 0);
    clear = 1'b0;

    // Clean press, then serve it.
    latency_check("clean");
    bus.sensor_raw = 1'b0;
    tick(12);
    check("clean_hold_x", 32'(bus.X), 1);
    bus.C = GREEN;
    tick(2);
    bus.C = RED;
    tick(1);
    check("clean_served_x", 32'(bus.X), 0);

    // Bounce rejection: 2 high, 1 low, 3 high.
    bus.sensor_raw = 1'b1;
    tick(2);
    bus.sensor_raw = 1'b0;
    tick(1);
    bus.sensor_raw = 1'b1;
    tick(3);
    bus.sensor_raw = 1'b0;
    tick(12);
    check("bounce_x", 32'(bus.X), 0);
    check("bounce_pending", 32'(bus.pending), 0);

    // Three arrivals, then service with no car left.
    repeat (3) press(10, 10);
    check("multi_pending", 32'(bus.pending), 3);
    check("multi_x", 32'(bus.X), 1);
    bus.C = GREEN;
    tick(3);
    check("multi_green_pending", 32'(bus.pending), 3);
    check("multi_green_x", 32'(bus.X), 1);
    bus.C = YELLOW;
    tick(1);
    check("multi_yellow_pending", 32'(bus.pending), 0);
    check("multi_yellow_x", 32'(bus.X), 0);
    bus.C = RED;
    tick(1);

    // Saturation, then a car still on the loop when green ends.
    repeat (9) press(10, 10);
    check("sat_pending", 32'(bus.pending), 7);
    press(10, 10);
    check("sat_hold_pending", 32'(bus.pending), 7);
    bus.C = GREEN;
    tick(1);
    bus.sensor_raw = 1'b1;
    tick(10);
    check("sat_serving_x", 32'(bus.X), 1);
    bus.C = YELLOW;
    tick(1);
    check("sat_remain_pending", 32'(bus.pending), 1);
    check("sat_remain_x", 32'(bus.X), 1);
    bus.C = RED;
    bus.sensor_raw = 1'b0;
    tick(12);
    bus.C = GREEN;
    tick(1);
    bus.C = RED;
    tick(1);
    check("sat_idle_x", 32'(bus.X), 0);
    check("sat_idle_pending", 32'(bus.pending), 0);

    // Stuck loop.
    bus.sensor_raw = 1'b1;
    tick(80);
    check("stuck_flag", 32'(bus.stuck), 1);
    check("stuck_req_x", 32'(bus.X), 1);
    check("stuck_req_pending", 32'(bus.pending), 1);
    bus.C = GREEN;
    tick(1);
    bus.C = YELLOW;
    tick(1);
    check("stuck_served_x", 32'(bus.X), 0);
    check("stuck_served_pending", 32'(bus.pending), 0);
    bus.C = RED;
    tick(20);
    check("stuck_norereq_x", 32'(bus.X), 0);
    check("stuck_norereq_pending", 32'(bus.pending), 0);
    check("stuck_sticky", 32'(bus.stuck), 1);
    bus.sensor_raw = 1'b0;
    tick(12);
    check("stuck_sticky_low", 32'(bus.stuck), 1);

    // Clear removes the stuck flag.
    clear = 1'b1;
    #2;
    check("clear_stuck", 32'(bus.stuck), 0);
    clear = 1'b0;
    tick(1);

    // Async reset mid-request.
    repeat (2) press(10, 10);
    check("midreq_pending", 32'(bus.pending), 2);
    check("midreq_x", 32'(bus.X), 1);
    clear = 1'b1;
    #2;
    check("async_x", 32'(bus.X), 0);
    check("async_pending", 32'(bus.pending), 0);
    check("async_stuck", 32'(bus.stuck), 0);
    #2;
    clear = 1'b0;
    latency_check("post_reset");
    bus.sensor_raw = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
